// File: rtl/aidc_lite_ahb_pkg.sv
// Purpose: shared AHB2 encodings, master indices and arbiter defaults for the AIDC lite bus.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aidc_lite_ahb_pkg;

  // Default number of hready beats an owner keeps the bus while the other master waits.
  localparam int TENURE_DEFAULT = 16;

  // Master indices on the shared bus.
  localparam logic MST_COMP   = 1'b0;  // compressor
  localparam logic MST_DECOMP = 1'b1;  // decompressor

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Arbiter ownership states; encoding doubles as the owning master index.
  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } arb_state_e;

  // Address-phase control bundle of one AHB2 master.
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
  } ahb_ctrl_t;

  // An owner may only be preempted on a transfer boundary: never inside a
  // burst (SEQ) or while it has the burst paused (BUSY).
  function automatic logic trans_is_boundary(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_IDLE);
  endfunction

endpackage

// File: rtl/aidc_lite_ahb_mst_mux.sv
// Purpose: AHB2 master-to-slave mux; address/control follow addr_sel, write data follows data_sel.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; hready stalls are handled by whoever drives the selects.
// Ports: m0_*/m1_* per-master address/control/wdata in; addr_sel = address-phase owner,
//        data_sel = data-phase owner; s_* muxed outputs to the slave.
module aidc_lite_ahb_mst_mux
  import aidc_lite_ahb_pkg::*;
(
  input  logic        addr_sel,
  input  logic        data_sel,
  input  logic [31:0] m0_haddr_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic        m0_hwrite_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [2:0]  m0_hburst_i,
  input  logic [3:0]  m0_hprot_i,
  input  logic [31:0] m0_hwdata_i,
  input  logic [31:0] m1_haddr_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic        m1_hwrite_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [2:0]  m1_hburst_i,
  input  logic [3:0]  m1_hprot_i,
  input  logic [31:0] m1_hwdata_i,
  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [2:0]  s_hburst_o,
  output logic [3:0]  s_hprot_o,
  output logic [31:0] s_hwdata_o
);

  ahb_ctrl_t m0_ctrl;
  ahb_ctrl_t m1_ctrl;
  ahb_ctrl_t sel_ctrl;

  assign m0_ctrl = '{haddr: m0_haddr_i, htrans: m0_htrans_i, hwrite: m0_hwrite_i,
                     hsize: m0_hsize_i, hburst: m0_hburst_i, hprot: m0_hprot_i};
  assign m1_ctrl = '{haddr: m1_haddr_i, htrans: m1_htrans_i, hwrite: m1_hwrite_i,
                     hsize: m1_hsize_i, hburst: m1_hburst_i, hprot: m1_hprot_i};

  assign sel_ctrl = (addr_sel == MST_DECOMP) ? m1_ctrl : m0_ctrl;

  assign s_haddr_o  = sel_ctrl.haddr;
  assign s_htrans_o = sel_ctrl.htrans;
  assign s_hwrite_o = sel_ctrl.hwrite;
  assign s_hsize_o  = sel_ctrl.hsize;
  assign s_hburst_o = sel_ctrl.hburst;
  assign s_hprot_o  = sel_ctrl.hprot;

  // Write data lags address by one accepted beat, so it uses the data-phase owner.
  assign s_hwdata_o = (data_sel == MST_DECOMP) ? m1_hwdata_i : m0_hwdata_i;

endmodule

// File: rtl/aidc_lite_ahb_arb.sv
// Purpose: two-master AHB2 arbiter (compressor/decompressor) with bounded tenure and parking.
// Latency: grant changes 1 cycle after the deciding hready beat; hmaster_o +1, hmaster_data_o +2.
// Backpressure: every register holds while hready_i=0; hresp is not observed.
// Ports: clk/rst (sync, active-high); m_hbusreq_i/m_hgrant_o per master; m0_*/m1_* master
//        AHB2 inputs; s_* muxed slave outputs; hready_i slave ready; hmaster_o/hmaster_data_o
//        address- and data-phase owner indices.
module aidc_lite_ahb_arb
  import aidc_lite_ahb_pkg::*;
#(
  parameter int TENURE = TENURE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_hbusreq_i,
  output logic [1:0]  m_hgrant_o,
  input  logic [31:0] m0_haddr_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic        m0_hwrite_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [2:0]  m0_hburst_i,
  input  logic [3:0]  m0_hprot_i,
  input  logic [31:0] m0_hwdata_i,
  input  logic [31:0] m1_haddr_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic        m1_hwrite_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [2:0]  m1_hburst_i,
  input  logic [3:0]  m1_hprot_i,
  input  logic [31:0] m1_hwdata_i,
  output logic [31:0] s_haddr_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [2:0]  s_hburst_o,
  output logic [3:0]  s_hprot_o,
  output logic [31:0] s_hwdata_o,
  input  logic        hready_i,
  output logic        hmaster_o,
  output logic        hmaster_data_o
);

  // A TENURE of 1 would give a zero-width counter; keep at least one bit.
  localparam int CW = (TENURE > 1) ? $clog2(TENURE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TENURE - 1);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic          hmaster_q;
  logic          hmaster_data_q;

  logic          owner_idx;
  logic          owner_req;
  logic          other_req;
  logic [1:0]    owner_htrans;
  logic          tenure_up;
  logic          rearb;
  logic          grant_change;

  assign owner_idx    = logic'(state_q);
  assign owner_req    = m_hbusreq_i[owner_idx];
  assign other_req    = m_hbusreq_i[~owner_idx];
  assign owner_htrans = (owner_idx == MST_DECOMP) ? m1_htrans_i : m0_htrans_i;
  assign tenure_up    = (cnt_q == CNT_MAX);

  // Re-arbitrate when the owner lets go, or when its tenure is spent and it
  // sits on a transfer boundary so no burst gets split.
  assign rearb = hready_i &&
                 (!owner_req || (other_req && tenure_up && trans_is_boundary(owner_htrans)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OWN0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_change = 1'b0;
    m_hgrant_o   = 2'b01;
    case (state_q)
      OWN0: begin
        m_hgrant_o = 2'b01;
        // With no competing request the bus parks with the current owner.
        if (rearb && other_req) begin
          state_d      = OWN1;
          grant_change = 1'b1;
        end
      end
      OWN1: begin
        m_hgrant_o = 2'b10;
        if (rearb && other_req) begin
          state_d      = OWN0;
          grant_change = 1'b1;
        end
      end
      default: begin
        state_d = OWN0;
      end
    endcase
  end

  // Tenure counter only runs while someone is actually waiting for the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hready_i) begin
      if (grant_change || !other_req) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Owner pipeline: the grant sampled on an accepted beat becomes the
  // address-phase owner, which becomes the data-phase owner one beat later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hmaster_q      <= MST_COMP;
      hmaster_data_q <= MST_COMP;
    end else if (hready_i) begin
      hmaster_q      <= owner_idx;
      hmaster_data_q <= hmaster_q;
    end
  end

  assign hmaster_o      = hmaster_q;
  assign hmaster_data_o = hmaster_data_q;

  aidc_lite_ahb_mst_mux u_mst_mux (
    .addr_sel    (hmaster_q),
    .data_sel    (hmaster_data_q),
    .m0_haddr_i  (m0_haddr_i),
    .m0_htrans_i (m0_htrans_i),
    .m0_hwrite_i (m0_hwrite_i),
    .m0_hsize_i  (m0_hsize_i),
    .m0_hburst_i (m0_hburst_i),
    .m0_hprot_i  (m0_hprot_i),
    .m0_hwdata_i (m0_hwdata_i),
    .m1_haddr_i  (m1_haddr_i),
    .m1_htrans_i (m1_htrans_i),
    .m1_hwrite_i (m1_hwrite_i),
    .m1_hsize_i  (m1_hsize_i),
    .m1_hburst_i (m1_hburst_i),
    .m1_hprot_i  (m1_hprot_i),
    .m1_hwdata_i (m1_hwdata_i),
    .s_haddr_o   (s_haddr_o),
    .s_htrans_o  (s_htrans_o),
    .s_hwrite_o  (s_hwrite_o),
    .s_hsize_o   (s_hsize_o),
    .s_hburst_o  (s_hburst_o),
    .s_hprot_o   (s_hprot_o),
    .s_hwdata_o  (s_hwdata_o)
  );

endmodule

// File: doc/aidc_lite_ahb_arb.md
AIDC_LITE_AHB_ARB -- requirements
Module: AIDC_LITE_AHB_ARB

Interface
- REQ-001 SHALL have parameter TENURE, default 16: max hready-beats the owner keeps the bus while the other master requests.
- REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
- REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
- REQ-004 SHALL have port m_hbusreq_i  in  2  bus request per master; bit0 = compressor, bit1 = decompressor.
- REQ-005 SHALL have port m_hgrant_o  out  2  one-hot grant per master.
- REQ-006 SHALL have ports m0_/m1_ haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i, hwdata_i  in  32/2/1/3/3/4/32  per-master AHB2 address/control and write data.
- REQ-007 SHALL have ports s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o, s_hwdata_o  out  32/2/1/3/3/4/32  muxed AHB2 to slave side.
- REQ-008 SHALL have port hready_i  in  1  slave hready; broadcast to both masters outside this block.
- REQ-009 SHALL have port hmaster_o  out  1  address-phase owner index.
- REQ-010 SHALL have port hmaster_data_o  out  1  data-phase owner index.

Function
- REQ-011 SHALL implement FSM states OWN0 and OWN1; m_hgrant_o = 2'b01 in OWN0, 2'b10 in OWN1; grant is always one-hot, and the bus parks with the last owner.
- REQ-012 SHALL evaluate state transitions only in cycles with hready_i=1; with hready_i=0, state, grant and counter hold.
- REQ-013 SHALL re-arbitrate when hready_i=1 and either (a) owner hbusreq=0, or (b) other hbusreq=1 and tenure counter = TENURE-1 and owner htrans is NONSEQ or IDLE (never SEQ/BUSY).
- REQ-014 SHALL, on re-arbitration, grant the other master if it requests, else keep the current owner (round-robin, park).
- REQ-015 SHALL update hmaster_o <= granted index on every hready_i=1 cycle, i.e. one cycle after the grant change is sampled.
- REQ-016 SHALL update hmaster_data_o <= hmaster_o on every hready_i=1 cycle.
- REQ-017 SHALL select all address/control s_* outputs combinationally from hmaster_o, and s_hwdata_o from hmaster_data_o.
- REQ-018 SHALL drive the tenure counter as follows: width $clog2(TENURE); increments on hready_i=1 while the other master requests and no grant change occurs; saturates at TENURE-1; clears to 0 on grant change or when the other master is not requesting.
- REQ-019 SHALL, when both masters deassert hbusreq simultaneously, keep the current owner (park); when both request in the same hready cycle the owner releases, the other master wins.
- REQ-020 SHALL ignore hresp; ERROR/RETRY/SPLIT responses do not affect arbitration.

Reset
- REQ-021 SHALL, while rst=1 at a clk edge, set state OWN0, m_hgrant_o=2'b01, hmaster_o=0, hmaster_data_o=0 and counter=0, regardless of hready_i or any in-flight transfer.
- REQ-022 SHALL, during reset, drive the s_* outputs as master 0's inputs per the REQ-017 mux.

Structure
- REQ-023 SHALL place HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), master indices and the TENURE default in shared package AIDC_LITE_AHB_PKG.
- REQ-024 SHALL implement the address/data muxing in one sub-module, AIDC_LITE_AHB_MST_MUX; FSM and counter stay in the top module.

Verification
- REQ-025 Bench SHALL cover: reset with both hbusreq=1 -> m_hgrant_o=01, hmaster_o=0, hmaster_data_o=0.
- REQ-026 Bench SHALL cover: m0 idle, m1 raises hbusreq, hready=1 -> grant=10 next cycle, hmaster_o=1 one cycle later, hmaster_data_o=1 one cycle after that.
- REQ-027 Bench SHALL cover: both request continuously, owner m0 issues NONSEQ singles, hready=1 -> handover to m1 after 16 beats; m1 then releases to m0 after 16 beats.
- REQ-028 Bench SHALL cover: m0 in INCR burst driving SEQ when the counter reaches 15 -> grant held until the first NONSEQ/IDLE beat, then granted to m1.
- REQ-029 Bench SHALL cover: hready=0 for 5 cycles while m0 drops hbusreq -> grant, hmaster_o and counter frozen; transfer happens on the first hready=1 cycle.
- REQ-030 Bench SHALL cover: rst=1 pulsed while owner=m1 mid-burst -> next cycle grant=01 and hmaster_o=0, s_haddr_o equals m0_haddr_i.
